mem_burst_master: RTL and testbench

Initiator-side burst engine that drives the single-port 32x32 synchronous RAM block (write-enable, read-enable, 5-bit address, 32-bit data in/out, registered read data with 1-cycle latency).
- Accepts one command per burst (read or write, start address, beat count).
- Streams write data in and read data out over valid/ready handshakes.
- Absorbs the RAM read latency and downstream backpressure with a 2-entry output buffer.
- Sits between the datapath and the RAM instance; it is the only driver of the RAM ports.

---
 rtl/mem_burst_master.sv | 151 +++++++++++++++
 tb/tb_mem_burst_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// Burst engine driving a single-port synchronous RAM: one command per burst,
// valid/ready write and read streams, 2-entry read buffer hides RAM latency.
module mem_burst_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              mem_wd_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // WRITE | accepting write beats, one RAM write per handshake
  // READ  | issuing RAM reads and draining the output buffer
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W:0]    remaining_q, remaining_d;
  logic [LEN_W:0]    issue_left_q, issue_left_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              pop;
  logic              issue_ok;
  logic [2:0]        occupancy;

  assign done = done_q;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    issue_left_d = issue_left_q;
    done_d       = 1'b0;
    buf_d        = buf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    wr_ready  = (state_q == WRITE);
    mem_wd_en = wr_ready & wr_valid;
    mem_din   = mem_wd_en ? wr_data : '0;
    mem_addr  = busy ? cur_addr_q : '0;
    rd_valid  = (count_q != 2'd0);
    rd_data   = buf_q[rd_ptr_q];
    pop       = rd_valid & rd_ready;

    // Buffered beats plus the one in flight must stay within the 2 buffer slots.
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue_ok   = (state_q == READ) && (occupancy < 3'd2) && (issue_left_q != '0);
    mem_rd_en  = issue_ok;
    inflight_d = issue_ok;

    if (inflight_q) begin
      buf_d[wr_ptr_q] = mem_dout;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d   = cmd_addr;
          remaining_d  = {1'b0, cmd_len} + CNT_ONE;
          issue_left_d = {1'b0, cmd_len} + CNT_ONE;
          state_d      = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (mem_wd_en) begin
          cur_addr_d  = cur_addr_q + 1'b1;
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue_ok) begin
          cur_addr_d   = cur_addr_q + 1'b1;
          issue_left_d = issue_left_q - CNT_ONE;
        end
        if (pop) begin
          remaining_d = remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      issue_left_q <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      issue_left_q <= issue_left_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
      buf_q        <= buf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural RAM and queue-based
// scoreboards for RAM writes, RAM read addresses and read-stream data.
module tb_mem_burst_master;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy, done;
  logic              mem_wd_en, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .mem_wd_en(mem_wd_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Single-port RAM, registered read data
  logic [DATA_W-1:0] ram [32];
  always @(posedge clk) begin
    if (mem_wd_en) ram[mem_addr] <= mem_din;
    if (mem_rd_en) mem_dout <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int occ_m = 0;

  logic [DATA_W-1:0] exp_mem [32];
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  logic [ADDR_W-1:0] ra_q[$];
  logic [DATA_W-1:0] rd_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: RAM traffic and popped read beats against pushed expectations
  always @(negedge clk) begin
    if (rst) begin
      occ_m = 0;
    end else begin
      if (mem_wd_en) begin
        check("wr_expected_pending", wa_q.size() != 0, 1'b1);
        if (wa_q.size() != 0) begin
          check("wr_addr", mem_addr, wa_q.pop_front());
          check("wr_data", mem_din, wd_q.pop_front());
        end
      end
      if (mem_rd_en) begin
        check("rd_issue_pending", ra_q.size() != 0, 1'b1);
        if (ra_q.size() != 0) check("rd_issue_addr", mem_addr, ra_q.pop_front());
        occ_m++;
      end
      if (rd_valid && rd_ready) begin
        check("rd_beat_pending", rd_q.size() != 0, 1'b1);
        if (rd_q.size() != 0) check("rd_data", rd_data, rd_q.pop_front());
        occ_m--;
      end
      if (mem_rd_en || rd_valid) check("occupancy_le2", occ_m <= 2, 1'b1);
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && n < 50) begin step(); n++; end
    check("cmd_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_len = ~l;
  endtask

  task automatic check_done(input int d0);
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_cmd_ready", cmd_ready, 1'b1);
    step();
    check("done_pulse_width", done, 1'b0);
    check("done_count", done_cnt - d0, 1);
  endtask

  task automatic write_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                             input logic [DATA_W-1:0] base, input logic [15:0] pat, input int plen);
    int beats = int'(l) + 1;
    int k = 0;
    int i = 0;
    int d0 = done_cnt;
    logic [ADDR_W-1:0] ad = a;
    send_cmd(1'b1, a, l);
    check("wr_busy", busy, 1'b1);
    check("wr_ready", wr_ready, 1'b1);
    while (k < beats && i < 200) begin
      if (i >= plen || pat[i[3:0]]) begin
        wr_valid = 1'b1;
        wr_data  = base + k;
        wa_q.push_back(ad);
        wd_q.push_back(base + k);
        exp_mem[ad] = base + k;
        ad++;
        k++;
      end else begin
        wr_valid = 1'b0;
        wr_data  = $urandom();
        #1;
        check("wr_gap_no_we", mem_wd_en, 1'b0);
      end
      i++;
      step();
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    check("wr_all_beats", wa_q.size(), 0);
    check_done(d0);
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                            input int stall_at, input int stall_len, input int rst_at);
    int beats = int'(l) + 1;
    int pops = 0;
    int cyc = 0;
    int lat = 1;
    int d0 = done_cnt;
    logic [ADDR_W-1:0] ad = a;
    for (int k = 0; k < beats; k++) begin
      ra_q.push_back(ad);
      rd_q.push_back(exp_mem[ad]);
      ad++;
    end
    rd_ready = 1'b1;
    send_cmd(1'b0, a, l);
    check("rd_first_issue", mem_rd_en, 1'b1);
    while (!rd_valid && lat < 20) begin step(); lat++; end
    check("rd_latency", lat, 3);
    while (pops < beats && cyc < 200) begin
      if (pops == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_rd_en", mem_rd_en, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        ra_q.delete();
        rd_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_access", mem_rd_en, 1'b0);
        return;
      end
      if (pops == stall_at) begin
        rd_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          check("stall_no_issue", mem_rd_en, 1'b0);
          check("stall_valid_held", rd_valid, 1'b1);
          step();
          cyc++;
        end
        rd_ready = 1'b1;
        stall_at = -1;
      end
      if (rd_valid) pops++;
      step();
      cyc++;
    end
    check("rd_cycles", cyc, beats + stall_len);
    check("rd_all_beats", rd_q.size(), 0);
    check("rd_all_issued", ra_q.size(), 0);
    check_done(d0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    step();
    step();
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, 0);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_wr_ready", wr_ready, 1'b0);
    check("reset_mem_wd_en", mem_wd_en, 1'b0);
    check("reset_mem_rd_en", mem_rd_en, 1'b0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_din", mem_din, 0);
    rst = 1'b0;
    #1;
    check("idle_cmd_ready", cmd_ready, 1'b1);
    step();

    write_burst(5'd3, 5'd3, 32'hA0, 16'h000F, 4);
    read_burst(5'd3, 5'd3, -1, 0, -1);
    write_burst(5'd7, 5'd3, 32'hB0, 16'h0059, 7);
    read_burst(5'd7, 5'd3, -1, 0, -1);
    read_burst(5'd3, 5'd7, 2, 5, -1);
    write_burst(5'd30, 5'd3, 32'h11, 16'h000F, 4);
    read_burst(5'd30, 5'd3, -1, 0, -1);
    read_burst(5'd3, 5'd7, -1, 0, 2);
    read_burst(5'd3, 5'd0, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
